dcache_miss_ctrl: RTL

Miss-handling and flush controller for the 2-way set-associative data cache. It sits beside the combinational hit/way-select logic and owns the sequencing around it:
- LRU state per set
- victim choice on a miss
- dirty-block writeback to memory
- two-word block refill
- end-of-program flush of every dirty block on halt

It drives the arbiter-facing memory port (dREN/dWEN/daddr/dstore) and the cache array fill/clean strobes.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/dcache_lru.sv | 41 ++++
 rtl/dcache_miss_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared D-cache types: address split, geometry constants and the miss controller state type.
package cpu_types_pkg;

  localparam int DSETS  = 8;
  localparam int DIDX_W = $clog2(DSETS);
  localparam int DTAG_W = 32 - DIDX_W - 3;

  typedef struct packed {
    logic [DTAG_W-1:0] tag;
    logic [DIDX_W-1:0] idx;
    logic              blkoff;
    logic [1:0]        bytoff;
  } dcachef_t;

  typedef enum logic [3:0] {
    IDLE,
    WB0,
    WB1,
    FILL0,
    FILL1,
    FLUSH,
    FWB0,
    FWB1,
    HALTED
  } dmiss_state_t;

endpackage

// File: rtl/dcache_lru.sv
// Per-set LRU bit register with one update port and combinational victim choice.
module dcache_lru
  import cpu_types_pkg::*;
#(
  parameter int SETS = DSETS,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_val,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             valid0,
  input  logic             valid1,
  output logic             victim
);

  logic [SETS-1:0] lru;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      lru <= '0;
    end else if (upd_en) begin
      lru[upd_idx] <= upd_val;
    end
  end

  // Empty ways are always filled first; LRU only decides between two valid ways.
  always_comb begin
    victim = 1'b0;
    if (!valid0) begin
      victim = 1'b0;
    end else if (!valid1) begin
      victim = 1'b1;
    end else begin
      victim = lru[rd_idx];
    end
  end

endmodule

// File: rtl/dcache_miss_ctrl.sv
// D-cache miss/flush controller: victim writeback, two-word refill, LRU upkeep, flush on halt.
// Build option DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
//
// state  | meaning
// IDLE   | serve hits, detect misses and halt
// WB0    | write back victim word 0
// WB1    | write back victim word 1
// FILL0  | read word 0 of missing block into victim way
// FILL1  | read word 1, write tag/valid, update LRU
// FLUSH  | examine way c[0] of set c[IDX_W:1]
// FWB0   | write back flushed word 0
// FWB1   | write back flushed word 1, clean the way
// HALTED | flush done, flushed held until reset
module dcache_miss_ctrl
  import cpu_types_pkg::*;
#(
  parameter int SETS  = DSETS,
  parameter int TAG_W = DTAG_W,
  parameter int WORDS = 2,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             dmemREN,
  input  logic             dmemWEN,
  input  logic [31:0]      dmemaddr,
  input  logic             halt,
  input  logic             miss,
  input  logic             setsel,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             vdirty,
  input  logic [TAG_W-1:0] vtag,
  input  logic [31:0]      vdata0,
  input  logic [31:0]      vdata1,
  output logic             victim_way,
  output logic             flush_sel,
  output logic [IDX_W-1:0] flush_idx,
  output logic             dhit,
  input  logic             dwait,
  input  logic [31:0]      dload,
  output logic             dREN,
  output logic             dWEN,
  output logic [31:0]      daddr,
  output logic [31:0]      dstore,
  output logic             fill_en,
  output logic             fill_word,
  output logic             fill_last,
  output logic             clean_en,
  output logic             flushed
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);

  if (WORDS != 2) begin : g_words_chk
    $error("dcache_miss_ctrl only supports two-word blocks");
  end
  if (TAG_W != 32 - IDX_W - 3) begin : g_tag_chk
    $error("dcache_miss_ctrl TAG_W must equal 32 - IDX_W - 3");
  end

  localparam logic [IDX_W:0] FCNT_LAST = (IDX_W+1)'(2*SETS-1);
  localparam logic [IDX_W:0] FCNT_ONE  = (IDX_W+1)'(1);

  dmiss_state_t     state;
  logic [TAG_W-1:0] lat_tag;
  logic [IDX_W-1:0] lat_idx;
  logic             miss_way;
  logic [IDX_W:0]   fcnt;

  logic             req;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic             victim_sel;
  logic             victim_valid;
  logic             flush_valid;
  logic             idle_hit;
  logic             idle_miss;
  logic             lru_upd_en;
  logic [IDX_W-1:0] lru_upd_idx;
  logic             lru_upd_val;
  logic             unused_bits;

  assign req          = dmemREN | dmemWEN;
  assign req_tag      = dmemaddr[31:IDX_W+3];
  assign req_idx      = dmemaddr[IDX_W+2:3];
  assign victim_valid = victim_sel ? valid1 : valid0;
  assign flush_valid  = fcnt[0] ? valid1 : valid0;
  assign idle_hit     = (state == IDLE) & req & ~miss & ~halt;
  assign idle_miss    = (state == IDLE) & req & miss & ~halt;
  assign unused_bits  = ^{dmemaddr[2:0], dload};

  // Hits make the other way LRU; a completed refill makes the refilled way MRU.
  always_comb begin
    lru_upd_en  = 1'b0;
    lru_upd_idx = req_idx;
    lru_upd_val = ~setsel;
    if (idle_hit) begin
      lru_upd_en = 1'b1;
    end else if (state == FILL1 && !dwait) begin
      lru_upd_en  = 1'b1;
      lru_upd_idx = lat_idx;
      lru_upd_val = ~miss_way;
    end
  end

  dcache_lru #(.SETS(SETS)) u_lru (
    .CLK     (CLK),
    .nRST    (nRST),
    .upd_en  (lru_upd_en),
    .upd_idx (lru_upd_idx),
    .upd_val (lru_upd_val),
    .rd_idx  (req_idx),
    .valid0  (valid0),
    .valid1  (valid1),
    .victim  (victim_sel)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state    <= IDLE;
      lat_tag  <= '0;
      lat_idx  <= '0;
      miss_way <= 1'b0;
      fcnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (halt) begin
            state <= FLUSH;
            fcnt  <= '0;
          end else if (req && miss) begin
            lat_tag  <= req_tag;
            lat_idx  <= req_idx;
            miss_way <= victim_sel;
            state    <= (victim_valid && vdirty) ? WB0 : FILL0;
          end
        end
        WB0:   if (!dwait) state <= WB1;
        WB1:   if (!dwait) state <= FILL0;
        FILL0: if (!dwait) state <= FILL1;
        FILL1: if (!dwait) state <= IDLE;
        FLUSH: begin
          if (flush_valid && vdirty) begin
            state <= FWB0;
          end else if (fcnt == FCNT_LAST) begin
            state <= HALTED;
          end else begin
            fcnt <= fcnt + FCNT_ONE;
          end
        end
        FWB0:  if (!dwait) state <= FWB1;
        FWB1: begin
          if (!dwait) begin
            if (fcnt == FCNT_LAST) begin
              state <= HALTED;
            end else begin
              fcnt  <= fcnt + FCNT_ONE;
              state <= FLUSH;
            end
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (idle_hit && hit_count != 32'hFFFF_FFFF) begin
        hit_count <= hit_count + 32'd1;
      end
      if (idle_miss && miss_count != 32'hFFFF_FFFF) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

  always_comb begin
    dhit       = 1'b0;
    victim_way = 1'b0;
    flush_sel  = 1'b0;
    flush_idx  = '0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    daddr      = '0;
    dstore     = '0;
    fill_en    = 1'b0;
    fill_word  = 1'b0;
    fill_last  = 1'b0;
    clean_en   = 1'b0;
    flushed    = 1'b0;
    case (state)
      IDLE: begin
        dhit       = idle_hit;
        victim_way = victim_sel;
      end
      WB0, WB1: begin
        victim_way = miss_way;
        dWEN       = 1'b1;
        daddr      = {vtag, lat_idx, state == WB1, 2'b00};
        dstore     = (state == WB1) ? vdata1 : vdata0;
      end
      FILL0, FILL1: begin
        victim_way = miss_way;
        dREN       = 1'b1;
        daddr      = {lat_tag, lat_idx, state == FILL1, 2'b00};
        fill_en    = ~dwait;
        fill_word  = (state == FILL1);
        fill_last  = (state == FILL1) & ~dwait;
      end
      FLUSH: begin
        flush_sel  = 1'b1;
        flush_idx  = fcnt[IDX_W:1];
        victim_way = fcnt[0];
      end
      FWB0, FWB1: begin
        flush_sel  = 1'b1;
        flush_idx  = fcnt[IDX_W:1];
        victim_way = fcnt[0];
        dWEN       = 1'b1;
        daddr      = {vtag, fcnt[IDX_W:1], state == FWB1, 2'b00};
        dstore     = (state == FWB1) ? vdata1 : vdata0;
        clean_en   = (state == FWB1) & ~dwait;
      end
      HALTED: flushed = 1'b1;
      default: ;
    endcase
  end

endmodule
